uart_rx: RTL and testbench

- UART receiver: the far-end counterpart of the UART transmitter.
- Deserialises an asynchronous frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Uses a programmable oversampling clock (Prescale edges per bit) with 3-sample majority voting.
- Delivers the byte on P_DATA with a one-cycle Data_Valid pulse; flags parity and stop-bit errors. Sits in the UART system between the serial line and the data sync/control logic.

---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// UART receiver interface bundle: serial line, frame configuration and
// the received-byte/error outputs. The line driver/config side is the
// master, the receiver is the slave.
interface uart_rx_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
);
    logic                   RX_IN;
    logic [PRESC_WIDTH-1:0] Prescale;
    logic                   PAR_EN;
    logic                   PAR_TYP;
    logic [DATA_WIDTH-1:0]  P_DATA;
    logic                   Data_Valid;
    logic                   Par_Err;
    logic                   Stop_Err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, Par_Err, Stop_Err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, Par_Err, Stop_Err
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, stop bit. Each bit is oversampled Prescale times; three
// samples around mid-bit are majority-voted and the bit is evaluated on
// the last edge of the bit. Result/error pulses appear one cycle after
// the stop bit ends.
module uart_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [PRESC_WIDTH-1:0] r_cnt;
    logic [PRESC_WIDTH-1:0] r_presc;
    logic                   r_par_en;
    logic                   r_par_typ;
    logic                   r_par_err;
    logic [BW-1:0]          r_bit_idx;
    logic [2:0]             r_samp;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_dv;
    logic                   r_pe;
    logic                   r_se;

    logic [PRESC_WIDTH-1:0] w_half;
    logic [2:0]             w_samp_pt;
    logic                   w_last;
    logic                   w_maj;
    logic                   w_par_exp;
    logic                   w_start;
    logic                   w_shift;
    logic                   w_par_chk;
    logic                   w_stop_eval;
    logic                   w_dv_next;
    logic                   w_pe_next;
    logic                   w_se_next;

    assign w_half    = {1'b0, r_presc[PRESC_WIDTH-1:1]};
    assign w_last    = (r_cnt == r_presc - PRESC_WIDTH'(1));
    assign w_maj     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
    assign w_par_exp = (^r_shift) ^ r_par_typ;

    // Sample points sit at Prescale/2-1, Prescale/2 and Prescale/2+1.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_samp_pt
            assign w_samp_pt[gi] = (r_cnt == (w_half + PRESC_WIDTH'(gi) - PRESC_WIDTH'(1)));
        end
    endgenerate

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    // Next-state logic; the frame shape uses the configuration latched at the start edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (!bus.RX_IN) w_state_next = START;
            START:   if (w_last) w_state_next = w_maj ? IDLE : DATA;
            DATA:    if (w_last && (r_bit_idx == BW'(DATA_WIDTH - 1)))
                         w_state_next = r_par_en ? PARITY : STOP;
            PARITY:  if (w_last) w_state_next = STOP;
            STOP:    if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Per-state control strobes and next values of the result pulses.
    always_comb begin
        w_start     = (r_state == IDLE) && !bus.RX_IN;
        w_shift     = (r_state == DATA) && w_last;
        w_par_chk   = (r_state == PARITY) && w_last;
        w_stop_eval = (r_state == STOP) && w_last;
        w_se_next   = w_stop_eval && !w_maj;
        w_pe_next   = w_stop_eval && w_maj && r_par_err;
        w_dv_next   = w_stop_eval && w_maj && !r_par_err;
    end

    // Edge counter and frame configuration; the start cycle itself is count 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt     <= '0;
            r_presc   <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_start) begin
            r_cnt     <= PRESC_WIDTH'(1);
            r_presc   <= bus.Prescale;
            r_par_en  <= bus.PAR_EN;
            r_par_typ <= bus.PAR_TYP;
        end else if (r_state != IDLE) begin
            r_cnt <= w_last ? '0 : r_cnt + PRESC_WIDTH'(1);
        end
    end

    // Capture the three mid-bit samples for the majority vote.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_samp <= '0;
        end else if (r_state != IDLE) begin
            for (int i = 0; i < 3; i++) begin
                if (w_samp_pt[i]) r_samp[i] <= bus.RX_IN;
            end
        end
    end

    // Data shift register, bit index and parity error flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_bit_idx <= '0;
                r_par_err <= 1'b0;
            end
            if (w_shift) begin
                r_shift   <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                r_bit_idx <= r_bit_idx + BW'(1);
            end
            if (w_par_chk) r_par_err <= (w_maj != w_par_exp);
        end
    end

    // Result pulses; P_DATA only moves on a clean frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data <= '0;
            r_dv   <= 1'b0;
            r_pe   <= 1'b0;
            r_se   <= 1'b0;
        end else begin
            r_dv <= w_dv_next;
            r_pe <= w_pe_next;
            r_se <= w_se_next;
            if (w_dv_next) r_data <= r_shift;
        end
    end

    assign bus.P_DATA     = r_data;
    assign bus.Data_Valid = r_dv;
    assign bus.Par_Err    = r_pe;
    assign bus.Stop_Err   = r_se;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives frames bit by bit, logs every output
// pulse with its cycle number and compares against hand-computed values.
module tb_uart_rx;
    logic CLK;
    logic RST;

    uart_rx_if #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) bus ();

    uart_rx #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Pulse monitor, sampled on the falling edge.
    int dv_n = 0;
    int pe_n = 0;
    int se_n = 0;
    int pe_cyc = 0;
    int se_cyc = 0;
    int dv_cyc_log [0:63];
    logic [7:0] dv_dat_log [0:63];

    always @(negedge CLK) begin
        if (bus.Data_Valid === 1'b1 && dv_n < 64) begin
            dv_cyc_log[dv_n] = cyc;
            dv_dat_log[dv_n] = bus.P_DATA;
            dv_n++;
        end
        if (bus.Par_Err === 1'b1) begin
            pe_cyc = cyc;
            pe_n++;
        end
        if (bus.Stop_Err === 1'b1) begin
            se_cyc = cyc;
            se_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    int last_start = 0;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            bus.RX_IN = 1'b1;
        end
    endtask

    // Drive one frame. flip_* inverts a single oversample; rst_* pulses reset
    // at that point and abandons the rest of the frame with the line idle.
    task automatic send_frame(input logic [7:0] data, input int presc, input bit pen,
                              input bit ptyp, input bit par_bit, input bit stop_bit,
                              input int flip_bit, input int flip_cnt,
                              input int rst_bit, input int rst_cnt);
        logic bits [0:10];
        int   nb;
        bit   aborted;
        nb = pen ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        bits[9]  = par_bit;
        bits[nb-1] = stop_bit;
        aborted = 1'b0;
        $display("frame data=0x%02h presc=%0d par_en=%0d par_typ=%0d par_bit=%0d stop=%0d",
                 data, presc, pen, ptyp, par_bit, stop_bit);
        for (int bi = 0; bi < nb; bi++) begin
            for (int c = 0; c < presc; c++) begin
                if (!aborted) begin
                    @(posedge CLK); #1;
                    if (bi == 0 && c == 0) begin
                        last_start   = cyc;
                        bus.Prescale = 6'(presc);
                        bus.PAR_EN   = pen;
                        bus.PAR_TYP  = ptyp;
                    end
                    if (bi == rst_bit && c == rst_cnt) begin
                        RST = 1'b0;
                        bus.RX_IN = 1'b1;
                        @(posedge CLK); #1;
                        RST = 1'b1;
                        aborted = 1'b1;
                    end else begin
                        bus.RX_IN = (bi == flip_bit && c == flip_cnt) ? ~bits[bi] : bits[bi];
                    end
                end
            end
        end
    endtask

    int b_dv, b_pe, b_se, t0;

    initial begin
        RST          = 1'b0;
        bus.RX_IN    = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_pdata", 32'(bus.P_DATA), 32'h0);
        chk("rst_dv",    32'(bus.Data_Valid), 32'h0);
        chk("rst_pe",    32'(bus.Par_Err), 32'h0);
        chk("rst_se",    32'(bus.Stop_Err), 32'h0);
        RST = 1'b1;
        idle(4);

        // Even parity, Prescale 8.
        b_dv = dv_n; b_pe = pe_n; b_se = se_n;
        send_frame(8'hA5, 8, 1, 0, 0, 1, -1, -1, -1, -1);
        idle(8);
        chk("t1_dv_cnt", 32'(dv_n - b_dv), 32'd1);
        chk("t1_dv_lat", 32'(dv_cyc_log[b_dv] - last_start), 32'd88);
        chk("t1_data",   32'(dv_dat_log[b_dv]), 32'hA5);
        chk("t1_err",    32'((pe_n - b_pe) + (se_n - b_se)), 32'd0);

        // Back-to-back frames, no parity, Prescale 16.
        b_dv = dv_n;
        send_frame(8'h3C, 16, 0, 0, 0, 1, -1, -1, -1, -1);
        t0 = last_start;
        send_frame(8'hC3, 16, 0, 0, 0, 1, -1, -1, -1, -1);
        idle(8);
        chk("t2_dv_cnt",  32'(dv_n - b_dv), 32'd2);
        chk("t2_lat0",    32'(dv_cyc_log[b_dv] - t0), 32'd160);
        chk("t2_data0",   32'(dv_dat_log[b_dv]), 32'h3C);
        chk("t2_lat1",    32'(dv_cyc_log[b_dv+1] - t0), 32'd320);
        chk("t2_data1",   32'(dv_dat_log[b_dv+1]), 32'hC3);
        chk("t2_pdata",   32'(bus.P_DATA), 32'hC3);

        // Odd parity with wrong parity bit.
        b_dv = dv_n; b_pe = pe_n; b_se = se_n;
        send_frame(8'hA5, 8, 1, 1, 0, 1, -1, -1, -1, -1);
        idle(8);
        chk("t3_pe_cnt", 32'(pe_n - b_pe), 32'd1);
        chk("t3_pe_lat", 32'(pe_cyc - last_start), 32'd88);
        chk("t3_dv_cnt", 32'(dv_n - b_dv), 32'd0);
        chk("t3_se_cnt", 32'(se_n - b_se), 32'd0);
        chk("t3_pdata",  32'(bus.P_DATA), 32'hC3);

        // Stop bit low, Prescale 32.
        b_dv = dv_n; b_pe = pe_n; b_se = se_n;
        send_frame(8'h55, 32, 0, 0, 0, 0, -1, -1, -1, -1);
        idle(8);
        chk("t4_se_cnt", 32'(se_n - b_se), 32'd1);
        chk("t4_se_lat", 32'(se_cyc - last_start), 32'd320);
        chk("t4_dv_cnt", 32'(dv_n - b_dv), 32'd0);
        chk("t4_pe_cnt", 32'(pe_n - b_pe), 32'd0);
        chk("t4_pdata",  32'(bus.P_DATA), 32'hC3);

        // Parity wrong and stop low together: stop error wins.
        b_dv = dv_n; b_pe = pe_n; b_se = se_n;
        send_frame(8'h01, 8, 1, 0, 0, 0, -1, -1, -1, -1);
        idle(8);
        chk("t5_se_cnt", 32'(se_n - b_se), 32'd1);
        chk("t5_pe_cnt", 32'(pe_n - b_pe), 32'd0);
        chk("t5_dv_cnt", 32'(dv_n - b_dv), 32'd0);

        // Two-cycle glitch on the start bit.
        b_dv = dv_n; b_pe = pe_n; b_se = se_n;
        $display("glitch low 2 cycles presc=8");
        @(posedge CLK); #1; bus.RX_IN = 1'b0;
        @(posedge CLK); #1; bus.RX_IN = 1'b0;
        idle(20);
        chk("t6_no_pulse", 32'((dv_n - b_dv) + (pe_n - b_pe) + (se_n - b_se)), 32'd0);

        // One corrupted oversample on data bit 0 is voted out.
        b_dv = dv_n;
        send_frame(8'h81, 8, 0, 0, 0, 1, 1, 4, -1, -1);
        idle(8);
        chk("t6_dv_cnt", 32'(dv_n - b_dv), 32'd1);
        chk("t6_dv_lat", 32'(dv_cyc_log[b_dv] - last_start), 32'd80);
        chk("t6_data",   32'(dv_dat_log[b_dv]), 32'h81);

        // Reset in the middle of data bit 4, then a clean parity frame.
        b_dv = dv_n; b_pe = pe_n; b_se = se_n;
        send_frame(8'h5A, 8, 0, 0, 0, 1, -1, -1, 5, 4);
        @(negedge CLK);
        chk("t7_rst_pdata", 32'(bus.P_DATA), 32'h0);
        chk("t7_rst_dv",    32'(bus.Data_Valid), 32'h0);
        idle(100);
        chk("t7_no_pulse", 32'((dv_n - b_dv) + (pe_n - b_pe) + (se_n - b_se)), 32'd0);
        b_dv = dv_n;
        send_frame(8'h7E, 8, 1, 0, 0, 1, -1, -1, -1, -1);
        idle(8);
        chk("t7_dv_cnt", 32'(dv_n - b_dv), 32'd1);
        chk("t7_dv_lat", 32'(dv_cyc_log[b_dv] - last_start), 32'd88);
        chk("t7_data",   32'(dv_dat_log[b_dv]), 32'h7E);
        chk("t7_pdata",  32'(bus.P_DATA), 32'h7E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
